// File: rtl/wb_arb_pkg.sv
// Shared definitions for the Wishbone round-robin arbiter: FSM encodings,
// outstanding-counter sizing and the synthetic flush read data.
package wb_arb_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANTED = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    // Read data returned with synthetic acks; sliced to the bus width by the user.
    localparam logic [63:0] FLUSH_DAT = '1;

    function automatic int unsigned out_width(input int unsigned max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: one-hot winner searching upward from last+1.
module rr_picker #(
    parameter int unsigned N  = 2,
    parameter int unsigned PW = 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [PW-1:0] i_last,
    output logic [N-1:0]  o_gnt_c
);

    logic w_found;

    always_comb begin
        o_gnt_c = '0;
        w_found = 1'b0;
        for (int off = 1; off <= int'(N); off++) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!w_found && i_req[i] && ((int'(i_last) + off) % int'(N)) == i) begin
                    o_gnt_c[i] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone slave between masters.
// Optional ack watchdog with synthetic-ack flush: define WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS     = 2,
    parameter int unsigned ADDR_BITS       = 8,
    parameter int unsigned BYTES           = 1,
    parameter int unsigned SEL_WIDTH       = 1,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
    input  logic                               clk,
    input  logic                               areset,
    input  logic [NUM_MASTERS*ADDR_BITS-1:0]   s_wb_addr,
    input  logic [NUM_MASTERS*BYTES*8-1:0]     s_wb_dat_m2s,
    input  logic [NUM_MASTERS-1:0]             s_wb_we,
    input  logic [NUM_MASTERS*SEL_WIDTH-1:0]   s_wb_sel,
    input  logic [NUM_MASTERS-1:0]             s_wb_stb,
    input  logic [NUM_MASTERS-1:0]             s_wb_cyc,
    output logic [NUM_MASTERS*BYTES*8-1:0]     s_wb_dat_s2m,
    output logic [NUM_MASTERS-1:0]             s_wb_ack,
    output logic [NUM_MASTERS-1:0]             s_wb_stall,
    output logic [ADDR_BITS-1:0]               m_wb_addr,
    output logic [BYTES*8-1:0]                 m_wb_dat_m2s,
    output logic                               m_wb_we,
    output logic [SEL_WIDTH-1:0]               m_wb_sel,
    output logic                               m_wb_stb,
    output logic                               m_wb_cyc,
    input  logic [BYTES*8-1:0]                 m_wb_dat_s2m,
    input  logic                               m_wb_ack,
    input  logic                               m_wb_stall,
    output logic [NUM_MASTERS-1:0]             grant
);

    localparam int unsigned DW = BYTES * 8;
    localparam int unsigned PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int unsigned OW = out_width(MAX_OUTSTANDING);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || MAX_OUTSTANDING < 1 || TIMEOUT_CYCLES < 2 || BYTES > 8)
    begin : g_param_check
        $error("wb_rr_arbiter: unsupported parameter set");
    end

    logic [1:0]             r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic [PW-1:0]          r_gidx;
    logic [PW-1:0]          r_last;
    logic [OW-1:0]          r_out;

    logic [1:0]             w_state_nxt;
    logic [NUM_MASTERS-1:0] w_grant_nxt;
    logic [PW-1:0]          w_gidx_nxt;
    logic [PW-1:0]          w_last_nxt;
    logic [OW-1:0]          w_out_nxt;

    logic [NUM_MASTERS-1:0] w_pick;
    logic [PW-1:0]          w_pick_idx;
    logic                   w_g_cyc;
    logic                   w_g_stb;
    logic                   w_g_we;
    logic [ADDR_BITS-1:0]   w_g_addr;
    logic [DW-1:0]          w_g_dat;
    logic [SEL_WIDTH-1:0]   w_g_sel;
    logic                   w_full;
    logic                   w_accept;
    logic                   w_ack_ok;
    logic                   w_flush;
    logic [DW-1:0]          w_dat;

    rr_picker #(
        .N  (NUM_MASTERS),
        .PW (PW)
    ) u_picker (
        .i_req   (s_wb_cyc),
        .i_last  (r_last),
        .o_gnt_c (w_pick)
    );

    // Mux the currently granted master's request fields and encode the pick.
    always_comb begin
        w_g_cyc    = 1'b0;
        w_g_stb    = 1'b0;
        w_g_we     = 1'b0;
        w_g_addr   = '0;
        w_g_dat    = '0;
        w_g_sel    = '0;
        w_pick_idx = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            if (r_gidx == PW'(i)) begin
                w_g_cyc  = s_wb_cyc[i];
                w_g_stb  = s_wb_stb[i];
                w_g_we   = s_wb_we[i];
                w_g_addr = s_wb_addr[i*ADDR_BITS +: ADDR_BITS];
                w_g_dat  = s_wb_dat_m2s[i*DW +: DW];
                w_g_sel  = s_wb_sel[i*SEL_WIDTH +: SEL_WIDTH];
            end
            if (w_pick[i]) begin
                w_pick_idx = PW'(i);
            end
        end
    end

    assign w_full       = (r_out == OW'(MAX_OUTSTANDING));
    assign w_accept     = m_wb_stb && !m_wb_stall;
    assign w_ack_ok     = m_wb_ack && (r_out != '0);
    assign w_flush      = (r_state == ST_FLUSH);
    assign w_dat        = w_flush ? FLUSH_DAT[DW-1:0] : m_wb_dat_s2m;
    assign s_wb_dat_s2m = {NUM_MASTERS{w_dat}};
    assign grant        = r_grant;
    assign m_wb_addr    = w_g_addr;
    assign m_wb_dat_m2s = w_g_dat;
    assign m_wb_we      = w_g_we;
    assign m_wb_sel     = w_g_sel;

    // Bus-side outputs follow the granted master live so a cyc drop is seen at once.
    always_comb begin
        m_wb_cyc   = 1'b0;
        m_wb_stb   = 1'b0;
        s_wb_ack   = '0;
        s_wb_stall = '1;
        case (r_state)
            ST_GRANTED: begin
                m_wb_cyc   = w_g_cyc;
                m_wb_stb   = w_g_cyc && w_g_stb && !w_full;
                s_wb_ack   = w_ack_ok ? r_grant : '0;
                s_wb_stall = ~r_grant | (r_grant & {NUM_MASTERS{m_wb_stall || w_full}});
            end
`ifdef WB_ARB_TIMEOUT_EN
            ST_FLUSH: begin
                s_wb_ack = (r_out != '0) ? r_grant : '0;
            end
`endif
            default: begin
                m_wb_cyc = 1'b0;
            end
        endcase
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nxt;
    logic          w_timeout;

    // Watchdog runs only while the slave owes acks and restarts on every ack.
    always_comb begin
        w_timer_nxt = '0;
        if (r_state == ST_GRANTED && w_g_cyc && r_out != '0 && !m_wb_ack) begin
            w_timer_nxt = r_timer + TW'(1);
        end
    end

    assign w_timeout = (r_state == ST_GRANTED) && (r_out != '0) && !m_wb_ack &&
                       (r_timer == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_timer <= '0;
        end else begin
            r_timer <= w_timer_nxt;
        end
    end
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_gidx_nxt  = r_gidx;
        w_last_nxt  = r_last;
        w_out_nxt   = r_out;
        case (r_state)
            ST_IDLE: begin
                w_out_nxt = '0;
                if (|s_wb_cyc) begin
                    w_state_nxt = ST_GRANTED;
                    w_grant_nxt = w_pick;
                    w_gidx_nxt  = w_pick_idx;
                end
            end
            ST_GRANTED: begin
                if (!w_g_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_last_nxt  = r_gidx;
                    w_out_nxt   = '0;
                end else begin
                    if (w_accept && !w_ack_ok) begin
                        w_out_nxt = r_out + OW'(1);
                    end else if (!w_accept && w_ack_ok) begin
                        w_out_nxt = r_out - OW'(1);
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    if (w_timeout) begin
                        w_state_nxt = ST_FLUSH;
                    end
`endif
                end
            end
`ifdef WB_ARB_TIMEOUT_EN
            // One synthetic ack per cycle until nothing is owed, then a fresh cycle.
            ST_FLUSH: begin
                if (!w_g_cyc) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_last_nxt  = r_gidx;
                    w_out_nxt   = '0;
                end else begin
                    if (r_out != '0) begin
                        w_out_nxt = r_out - OW'(1);
                    end
                    if (r_out <= OW'(1)) begin
                        w_state_nxt = ST_GRANTED;
                    end
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_out_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_last  <= PW'(NUM_MASTERS - 1);
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_gidx  <= w_gidx_nxt;
            r_last  <= w_last_nxt;
            r_out   <= w_out_nxt;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (default build, 2 masters, MAX_OUTSTANDING=4).
module tb_wb_rr_arbiter;

    logic        clk = 1'b0;
    logic        areset;
    logic [15:0] s_wb_addr;
    logic [15:0] s_wb_dat_m2s;
    logic [1:0]  s_wb_we;
    logic [1:0]  s_wb_sel;
    logic [1:0]  s_wb_stb;
    logic [1:0]  s_wb_cyc;
    logic [15:0] s_wb_dat_s2m;
    logic [1:0]  s_wb_ack;
    logic [1:0]  s_wb_stall;
    logic [7:0]  m_wb_addr;
    logic [7:0]  m_wb_dat_m2s;
    logic        m_wb_we;
    logic [0:0]  m_wb_sel;
    logic        m_wb_stb;
    logic        m_wb_cyc;
    logic [7:0]  m_wb_dat_s2m;
    logic        m_wb_ack;
    logic        m_wb_stall;
    logic [1:0]  grant;

    int checks = 0;
    int errors = 0;
    int acc    = 0;

    wb_rr_arbiter dut (
        .clk          (clk),
        .areset       (areset),
        .s_wb_addr    (s_wb_addr),
        .s_wb_dat_m2s (s_wb_dat_m2s),
        .s_wb_we      (s_wb_we),
        .s_wb_sel     (s_wb_sel),
        .s_wb_stb     (s_wb_stb),
        .s_wb_cyc     (s_wb_cyc),
        .s_wb_dat_s2m (s_wb_dat_s2m),
        .s_wb_ack     (s_wb_ack),
        .s_wb_stall   (s_wb_stall),
        .m_wb_addr    (m_wb_addr),
        .m_wb_dat_m2s (m_wb_dat_m2s),
        .m_wb_we      (m_wb_we),
        .m_wb_sel     (m_wb_sel),
        .m_wb_stb     (m_wb_stb),
        .m_wb_cyc     (m_wb_cyc),
        .m_wb_dat_s2m (m_wb_dat_s2m),
        .m_wb_ack     (m_wb_ack),
        .m_wb_stall   (m_wb_stall),
        .grant        (grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        areset       = 1'b1;
        s_wb_addr    = '0;
        s_wb_dat_m2s = '0;
        s_wb_we      = '0;
        s_wb_sel     = '0;
        s_wb_stb     = '0;
        s_wb_cyc     = '0;
        m_wb_dat_s2m = '0;
        m_wb_ack     = 1'b0;
        m_wb_stall   = 1'b0;
        #2;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_cyc",   32'(m_wb_cyc), 32'h0);
        chk("rst_stb",   32'(m_wb_stb), 32'h0);
        chk("rst_ack",   32'(s_wb_ack), 32'h0);
        chk("rst_stall", 32'(s_wb_stall), 32'h3);
        step();
        step();

        // Master 0 alone: write 0x5A to 0x04
        areset       = 1'b0;
        s_wb_cyc     = 2'b01;
        s_wb_stb     = 2'b01;
        s_wb_we      = 2'b01;
        s_wb_sel     = 2'b01;
        s_wb_addr    = 16'h0004;
        s_wb_dat_m2s = 16'h005A;
        #1;
        chk("t1_arb_latency_cyc", 32'(m_wb_cyc), 32'h0);
        chk("t1_arb_latency_grant", 32'(grant), 32'h0);
        step();
        chk("t1_grant",  32'(grant), 32'h1);
        chk("t1_cyc",    32'(m_wb_cyc), 32'h1);
        chk("t1_stb",    32'(m_wb_stb), 32'h1);
        chk("t1_addr",   32'(m_wb_addr), 32'h04);
        chk("t1_dat",    32'(m_wb_dat_m2s), 32'h5A);
        chk("t1_we",     32'(m_wb_we), 32'h1);
        chk("t1_sel",    32'(m_wb_sel), 32'h1);
        chk("t1_stall",  32'(s_wb_stall), 32'h2);
        step();
        s_wb_stb     = 2'b00;
        m_wb_ack     = 1'b1;
        m_wb_dat_s2m = 8'hC3;
        #1;
        chk("t1_ack",    32'(s_wb_ack), 32'h1);
        chk("t1_rdata",  32'(s_wb_dat_s2m), 32'hC3C3);
        chk("t1_stall1", 32'(s_wb_stall[1]), 32'h1);
        step();
        m_wb_ack = 1'b0;
        s_wb_cyc = 2'b00;
        #1;
        chk("t1_ack_once",   32'(s_wb_ack), 32'h0);
        chk("t1_release_cyc", 32'(m_wb_cyc), 32'h0);
        step();
        chk("t1_idle_grant", 32'(grant), 32'h0);

        // Both request together from reset: 0, gap, 1, gap, 0
        areset = 1'b1;
        #1;
        areset   = 1'b0;
        s_wb_cyc = 2'b11;
        s_wb_we  = 2'b00;
        step();
        chk("t2_first_grant", 32'(grant), 32'h1);
        s_wb_cyc = 2'b10;
        #1;
        chk("t2_release_cyc", 32'(m_wb_cyc), 32'h0);
        step();
        chk("t2_gap_grant", 32'(grant), 32'h0);
        chk("t2_gap_cyc",   32'(m_wb_cyc), 32'h0);
        step();
        chk("t2_second_grant", 32'(grant), 32'h2);
        chk("t2_second_cyc",   32'(m_wb_cyc), 32'h1);
        chk("t2_second_stall", 32'(s_wb_stall), 32'h1);
        s_wb_cyc = 2'b01;
        step();
        chk("t2_gap2_grant", 32'(grant), 32'h0);
        step();
        chk("t2_third_grant", 32'(grant), 32'h1);

        // Six back-to-back strobes, silent slave, limit of 4 outstanding
        s_wb_stb   = 2'b01;
        m_wb_stall = 1'b1;
        #1;
        chk("t3_stall_pass", 32'(s_wb_stall[0]), 32'h1);
        step();
        m_wb_stall = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (m_wb_stb && !m_wb_stall) acc++;
            step();
        end
        chk("t3_accepted", 32'(acc), 32'd4);
        chk("t3_full_stall", 32'(s_wb_stall[0]), 32'h1);
        chk("t3_full_stb",   32'(m_wb_stb), 32'h0);
        m_wb_ack = 1'b1;
        #1;
        chk("t3_drainA_ack",   32'(s_wb_ack), 32'h1);
        chk("t3_drainA_stb",   32'(m_wb_stb), 32'h0);
        step();
        chk("t3_drainB_stb",   32'(m_wb_stb), 32'h1);
        chk("t3_drainB_ack",   32'(s_wb_ack), 32'h1);
        chk("t3_drainB_stall", 32'(s_wb_stall[0]), 32'h0);
        step();
        chk("t3_ackstb_same_cycle", 32'(m_wb_stb), 32'h1);
        step();
        s_wb_stb = 2'b00;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_drain_ack", 32'(s_wb_ack), 32'h1);
            step();
        end
        #1;
        chk("t3_spurious_ack", 32'(s_wb_ack), 32'h0);
        m_wb_ack = 1'b0;

        // Async reset mid-burst while master 1 holds the grant
        s_wb_cyc = 2'b10;
        s_wb_stb = 2'b10;
        #1;
        chk("t4_release_cyc", 32'(m_wb_cyc), 32'h0);
        step();
        step();
        chk("t4_grant1", 32'(grant), 32'h2);
        step();
        areset = 1'b1;
        #1;
        chk("t4_async_grant", 32'(grant), 32'h0);
        chk("t4_async_cyc",   32'(m_wb_cyc), 32'h0);
        chk("t4_async_stall", 32'(s_wb_stall), 32'h3);
        areset   = 1'b0;
        s_wb_cyc = 2'b01;
        s_wb_stb = 2'b00;
        step();
        chk("t4_regrant",     32'(grant), 32'h1);
        chk("t4_regrant_cyc", 32'(m_wb_cyc), 32'h1);
        s_wb_cyc = 2'b00;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that shares one pipelined Wishbone slave (e.g. wb_to_spi_master) between NUM_MASTERS Wishbone masters, such as a serial_wb_master and an on-chip boot sequencer.
- Grants the slave to one master per bus cycle (cyc high period) and routes stb/we/addr/data/sel downstream and ack/stall/data upstream.
- Tracks outstanding transactions so the slave is never left with orphaned acks.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
ADDR_BITS, 8, Wishbone address width
BYTES, 1, data width in bytes
SEL_WIDTH, 1, select width
MAX_OUTSTANDING, 4, maximum accepted-but-unacked requests per grant
TIMEOUT_CYCLES, 1024, ack watchdog limit (used only with WB_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock
areset  in  1  reset; asynchronous, active-high
s_wb_addr/dat_m2s/we/sel/stb/cyc  in  NUM_MASTERS x field width  packed master-side requests, master 0 in the LSBs
s_wb_dat_s2m  out  NUM_MASTERS*BYTES*8  read data to masters (broadcast)
s_wb_ack  out  NUM_MASTERS  per-master ack
s_wb_stall  out  NUM_MASTERS  per-master stall
m_wb_addr/dat_m2s/we/sel/stb/cyc  out  field width  to shared slave
m_wb_dat_s2m  in  BYTES*8  slave read data
m_wb_ack  in  1  slave ack
m_wb_stall  in  1  slave stall
grant  out  NUM_MASTERS  one-hot current grant, 0 when idle

Behaviour:
- Reset values: grant=0, state IDLE, outstanding=0, last-granted pointer=NUM_MASTERS-1 (so master 0 wins first), m_wb_cyc=0, m_wb_stb=0, all s_wb_ack=0, all s_wb_stall=1.
- States:
  - IDLE: no grant; all stalls high; m_wb_cyc=0.
  - GRANTED: one master connected.
  - FLUSH: exists only with the macro.
- IDLE->GRANTED: any s_wb_cyc high. The winner is the first requester searching upward from (last+1) mod NUM_MASTERS. grant is registered; the slave sees cyc/stb one cycle after the request (1-cycle arbitration latency). The winner's held stb is forwarded in the first GRANTED cycle.
- In GRANTED:
  - m_wb_cyc = granted cyc.
  - m_wb_stb = granted stb && !full.
  - granted stall = m_wb_stall || full.
  - granted ack = m_wb_ack.
  - Non-granted masters: stall=1, ack=0.
- full = (outstanding == MAX_OUTSTANDING).
- outstanding counter:
  - +1 on m_wb_stb && !m_wb_stall.
  - -1 on m_wb_ack.
  - Both in the same cycle: unchanged.
  - Never wraps. Decrement at 0 is ignored (a spurious ack is dropped).
- Grant release: granted s_wb_cyc low forces m_wb_cyc low in the same cycle (combinational). Next edge: state IDLE, last pointer updated, outstanding cleared (Wishbone abort semantics). A release and a new request arriving together still cost 1 IDLE cycle, which guarantees a cyc-low gap at the slave.
- No preemption: a master holding cyc keeps the grant indefinitely.
- s_wb_dat_s2m: m_wb_dat_s2m replicated to every master. Only ack qualifies it.
- Reset mid-transfer: all state clears asynchronously. m_wb_cyc drops immediately.

Optional Feature:
WB_ARB_TIMEOUT_EN
- Defined:
  - A counter runs while outstanding>0 and resets on every m_wb_ack.
  - At TIMEOUT_CYCLES with no ack, the arbiter enters FLUSH and drops m_wb_cyc.
  - In FLUSH it issues one synthetic ack per cycle to the granted master, with dat_s2m all-ones, until outstanding=0. It holds the master's stall=1 throughout.
  - It then returns to GRANTED with a fresh cycle, or to IDLE if the master dropped cyc.
  - m_wb_ack in FLUSH is ignored.
- Undefined: no counter and no FLUSH state; a hung slave hangs the granted master.

Decomposition:
- Package wb_arb_pkg: state enum (IDLE, GRANTED, FLUSH), an outstanding-width function $clog2(MAX_OUTSTANDING+1), and the all-ones flush data constant.
- Sub-module rr_picker: given a request vector and the last pointer, returns a one-hot winner. It is purely combinational and unit-testable.

Test Plan:
- Master 0 alone writes 0x5A to addr 0x04 → m_wb_cyc is high 1 cycle after s_wb_cyc[0], grant=01, s_wb_ack[0] pulses once, s_wb_stall[1]=1 throughout.
- Both masters request at the same cycle from reset → master 0 is granted first. After it drops cyc there is 1 IDLE cycle, then grant=10. A third round returns to master 0.
- Granted master issues 6 back-to-back stb with the slave never acking, MAX_OUTSTANDING=4 → exactly 4 m_wb_stb accepted, stall held high. Acks then drain and the remaining 2 issue.
- Slave asserts m_wb_ack and accepts a new stb in the same cycle → outstanding is unchanged. An ack with outstanding=0 is dropped and no s_wb_ack is asserted.
- areset asserted mid-burst with grant=10 → grant=0, m_wb_cyc=0 and all stalls high without waiting for a clock edge. After release, a fresh request from master 0 is granted normally.
- With WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, 2 outstanding and the slave silent → at cycle 16 m_wb_cyc drops and s_wb_ack pulses twice with data 0xFF, then the master is regranted.
